// File: rtl/aux_regen.sv
// aux_regen: regenerates the aux data-enable (ade) and the aux nibbles from
// the receive-side aux FIFO. Each aux period is a run of BEATS FIFO words; the
// head word carries a first-word marker and a ctim horizontal position. When
// hcnt reaches ctim during blanking, the period is replayed as BEATS
// consecutive ade cycles, starting two cycles after the hcnt match.
//
// Ports:
//   fifo_clk        pixel-rate clock (sole clock)
//   sys_rst         synchronous active-high reset
//   hcnt[10:0]      current horizontal pixel count
//   vde             video data enable
//   axdout[24:0]    FIFO output: [24:14] ctim, [13] first-word marker,
//                   [12] unused, [11:0] {aux2,aux1,aux0}
//   axempty         FIFO empty
//   ax_rd_en        FIFO read strobe (FIFO Q updates the cycle after)
//   ade             regenerated aux data enable
//   aux0/aux1/aux2  regenerated aux nibbles
//   sync_err        sticky error flag, cleared only by reset
module aux_regen #(
  parameter int unsigned BEATS = 32
) (
  input  logic        fifo_clk,
  input  logic        sys_rst,
  input  logic [10:0] hcnt,
  input  logic        vde,
  input  logic [24:0] axdout,
  input  logic        axempty,
  output logic        ax_rd_en,
  output logic        ade,
  output logic [3:0]  aux0,
  output logic [3:0]  aux1,
  output logic [3:0]  aux2,
  output logic        sync_err
);

  localparam int unsigned BW = $clog2(BEATS) + 1;

  typedef enum logic [2:0] {
    S_INIT,
    S_PREFETCH,
    S_WAIT,
    S_BURST,
    S_DISCARD
  } state_e;

  state_e        state_q;
  logic          vde_q;
  logic          q_valid_q;
  logic [BW-1:0] beat_q;
  logic [BW-1:0] beat_d;
  logic          ade_q;
  logic [11:0]   aux_q;
  logic          sync_err_q;

  logic [10:0]   ctim;
  logic          marker;
  logic          vde_rise;
  logic          ctim_hit;
  logic          last_beat;
  logic          rd_want;
  logic          unused_bit12;

  // FIFO word fields
  assign ctim         = axdout[24:14];
  assign marker       = axdout[13];
  assign unused_bit12 = axdout[12];

  assign vde_rise  = vde & ~vde_q;
  // ctim is already compensated upstream: plain equality, only in blanking
  assign ctim_hit  = q_valid_q & marker & ~vde & (hcnt == ctim);
  assign beat_d    = beat_q + BW'(1);
  assign last_beat = (beat_q == BW'(BEATS - 1));

  // Per-state read request; DISCARD stops on a valid head so it is kept in Q
  always_comb begin
    rd_want = 1'b0;
    case (state_q)
      S_PREFETCH: rd_want = 1'b1;
      S_BURST:    rd_want = 1'b1;
      S_DISCARD:  rd_want = ~(q_valid_q & marker);
      default:    rd_want = 1'b0;
    endcase
  end

  // Never strobe an empty FIFO, and never while reset is being applied
  assign ax_rd_en = rd_want & ~axempty & ~sys_rst;

  // Sequencer with registered outputs
  always_ff @(posedge fifo_clk) begin
    if (sys_rst) begin
      state_q    <= S_INIT;
      vde_q      <= 1'b1;  // a true 0->1 of vde is needed to leave INIT
      q_valid_q  <= 1'b0;
      beat_q     <= '0;
      ade_q      <= 1'b0;
      aux_q      <= '0;
      sync_err_q <= 1'b0;
    end else begin
      vde_q <= vde;
      // Q holds a real word iff the last request found the FIFO non-empty
      if (rd_want) begin
        q_valid_q <= ~axempty;
      end
      ade_q <= 1'b0;
      aux_q <= '0;

      case (state_q)
        S_INIT: begin
          if (vde_rise) begin
            state_q <= S_PREFETCH;
          end
        end

        S_PREFETCH: begin
          if (!axempty) begin
            state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (!q_valid_q) begin
            state_q <= S_PREFETCH;
          end else if (!marker) begin
            sync_err_q <= 1'b1;
            state_q    <= S_DISCARD;
          end else if (ctim_hit) begin
            beat_q  <= '0;
            state_q <= S_BURST;
          end
        end

        S_BURST: begin
          if (vde_rise) begin
            // Active video came back mid-period: abandon it
            sync_err_q <= 1'b1;
            beat_q     <= '0;
            state_q    <= S_DISCARD;
          end else begin
            ade_q <= 1'b1;
            // Underflowed beats still count toward BEATS but carry zeros
            if (q_valid_q) begin
              aux_q <= axdout[11:0];
            end else begin
              sync_err_q <= 1'b1;
            end
            if (last_beat) begin
              beat_q  <= '0;
              state_q <= S_WAIT;
            end else begin
              beat_q <= beat_d;
            end
          end
        end

        S_DISCARD: begin
          if (q_valid_q && marker) begin
            state_q <= S_WAIT;
          end else if (axempty) begin
            state_q <= S_PREFETCH;
          end
        end

        default: state_q <= S_INIT;
      endcase
    end
  end

  assign ade      = ade_q;
  assign aux0     = aux_q[3:0];
  assign aux1     = aux_q[7:4];
  assign aux2     = aux_q[11:8];
  assign sync_err = sync_err_q;

endmodule
